writeback_stage_pipe: RTL and testbench

Parametrised MEM/WB pipeline register plus writeback stage for the pipelined RISC-V core.
- Registers the memory-stage results and selects the register-file write value from three sources.
- Sign- or zero-extends sub-word load data.
- Supports stall and flush (bubble insertion).
- Drives the register-file write port and the WB-stage forwarding source.

---
 rtl/writeback_stage_pipe.sv | 128 ++++++++++++
 tb/tb_writeback_stage_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage_pipe.sv
// MEM/WB pipeline register plus writeback result selection and load extension.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [XLEN-1:0]       ReadDataM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [REG_ADDR_W-1:0] RdM,
  output logic                  RegWriteW_wb,
  output logic [REG_ADDR_W-1:0] RdW_wb,
  output logic [XLEN-1:0]       ResultW,
  output logic                  ValidW
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      RetireCount
`endif
);

  localparam int OFF_W = $clog2(XLEN / 8);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            src;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       rdata;
    logic [XLEN-1:0]       pc4;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  mem_wb_t d;
  mem_wb_t q;

  always_comb begin
    d.valid     = ValidM;
    d.reg_write = RegWriteM;
    d.src       = ResultSrcM;
    d.funct3    = Funct3M;
    d.alu       = ALUResultM;
    d.rdata     = ReadDataM;
    d.pc4       = PCPlus4M;
    d.rd        = RdM;
  end

  // Flush beats stall so a held slot can still be squashed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (FlushW) begin
      q <= '0;
    end else if (!StallW) begin
      q <= d;
    end
  end

  logic [OFF_W-1:0] off;
  logic [OFF_W+2:0] byte_sh;
  logic [OFF_W+2:0] half_sh;
  logic [5:0]       word_sh;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [31:0]      word_lane;
  logic [XLEN-1:0]  load_val;

  assign off     = q.alu[OFF_W-1:0];
  assign byte_sh = {off, 3'b000};
  assign half_sh = {off[OFF_W-1:1], 4'b0000};
  assign word_sh = (XLEN == 64) ? {off[OFF_W-1], 5'b00000} : 6'd0;

  assign byte_lane = 8'(q.rdata >> byte_sh);
  assign half_lane = 16'(q.rdata >> half_sh);
  assign word_lane = 32'(q.rdata >> word_sh);

  // On RV32 the word lane is the whole datum, so LW/LWU pass it raw.
  always_comb begin
    load_val = q.rdata;
    case (q.funct3)
      3'b000:  load_val = XLEN'($signed(byte_lane));
      3'b001:  load_val = XLEN'($signed(half_lane));
      3'b010:  load_val = XLEN'($signed(word_lane));
      3'b100:  load_val = XLEN'(byte_lane);
      3'b101:  load_val = XLEN'(half_lane);
      3'b110:  load_val = XLEN'(word_lane);
      default: load_val = q.rdata;
    endcase
  end

  always_comb begin
    ResultW = q.alu;
    case (q.src)
      2'b01:   ResultW = load_val;
      2'b10:   ResultW = q.pc4;
      default: ResultW = q.alu;
    endcase
  end

  assign RegWriteW_wb = q.reg_write & q.valid & (q.rd != '0);
  assign RdW_wb       = q.rd;
  assign ValidW       = q.valid;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;

  // A stalled slot is counted only on the edge where it finally leaves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (q.valid && !StallW) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign RetireCount = cnt;
`endif

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Bench for writeback_stage_pipe: vector table, corner sequences, random vs model.
// Retire counter checks are compiled in when WB_RETIRE_CNT_EN is defined.
module tb_writeback_stage_pipe;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]      ResultSrcM;
  logic [2:0]      Funct3M;
  logic [XLEN-1:0] ALUResultM, ReadDataM, PCPlus4M;
  logic [RW-1:0]   RdM;
  logic            RegWriteW_wb;
  logic [RW-1:0]   RdW_wb;
  logic [XLEN-1:0] ResultW;
  logic            ValidW;
`ifdef WB_RETIRE_CNT_EN
  logic [CW-1:0]   RetireCount;
`endif

  always #5 clk = ~clk;

  writeback_stage_pipe #(
    .XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteW_wb(RegWriteW_wb), .RdW_wb(RdW_wb),
    .ResultW(ResultW), .ValidW(ValidW)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCount(RetireCount)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state: the instruction the spec says is sitting in WB.
  logic        m_valid, m_rw;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_rdata, m_pc4;
  int          m_rd;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] data);
    int unsigned b, h, idx;
    idx = addr % 4;
    b = (data >> (8 * idx)) % 256;
    h = (data >> (16 * (idx / 2))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    if (m_src == 2'd1) return ref_load(m_f3, m_alu, m_rdata);
    if (m_src == 2'd2) return m_pc4;
    return m_alu;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0;
    m_alu = 0; m_rdata = 0; m_pc4 = 0; m_rd = 0;
  endtask

  task automatic tick();
    if (!rst) begin
      model_clear();
      m_cnt = 0;
    end else begin
      if (m_valid && !StallW) m_cnt = (m_cnt + 1) % (1 << CW);
      if (FlushW) model_clear();
      else if (!StallW) begin
        m_valid = ValidM; m_rw = RegWriteM; m_src = ResultSrcM;
        m_f3 = Funct3M; m_alu = ALUResultM; m_rdata = ReadDataM;
        m_pc4 = PCPlus4M; m_rd = int'(RdM);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] s,
      input logic [2:0] f, input logic [31:0] a, input logic [31:0] r,
      input logic [31:0] p, input logic [4:0] rd);
    ValidM = v; RegWriteM = w; ResultSrcM = s; Funct3M = f;
    ALUResultM = a; ReadDataM = r; PCPlus4M = p; RdM = rd;
  endtask

  typedef struct {
    string       name;
    logic        v, w;
    logic [1:0]  s;
    logic [2:0]  f;
    logic [31:0] a, r, p;
    logic [4:0]  rd;
    logic [31:0] e_res;
    logic        e_we;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic v, input logic w,
      input logic [1:0] s, input logic [2:0] f, input logic [31:0] a,
      input logic [31:0] r, input logic [31:0] p, input logic [4:0] rd,
      input logic [31:0] er, input logic ew);
    vec_t x;
    x.name = n; x.v = v; x.w = w; x.s = s; x.f = f; x.a = a;
    x.r = r; x.p = p; x.rd = rd; x.e_res = er; x.e_we = ew;
    vecs.push_back(x);
  endtask

  initial begin
    rst = 0; StallW = 0; FlushW = 0;
    model_clear();
    m_cnt = 0;
    drive(1, 1, 2'd1, 3'd0, 32'h104, 32'hDEAD_BEEF, 32'h88, 5'd9);

    // Reset with nonzero inputs.
    tick();
    tick();
    chk("rst_valid", 64'(ValidW), 0);
    chk("rst_we", 64'(RegWriteW_wb), 0);
    chk("rst_rd", 64'(RdW_wb), 0);
    chk("rst_res", 64'(ResultW), 0);
    rst = 1;
    drive(1, 1, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0, 5'd3);
    tick();
    chk("post_rst_res", 64'(ResultW), 64'h55);
    chk("post_rst_rd", 64'(RdW_wb), 3);
    chk("post_rst_we", 64'(RegWriteW_wb), 1);

    add("lb",   1, 1, 1, 3'b000, 32'h100, 32'h8000_F0A5, 0, 1, 32'hFFFF_FFA5, 1);
    add("lbu",  1, 1, 1, 3'b100, 32'h101, 32'h8000_F0A5, 0, 2, 32'h0000_00F0, 1);
    add("lh",   1, 1, 1, 3'b001, 32'h102, 32'h8000_F0A5, 0, 3, 32'hFFFF_8000, 1);
    add("lhu",  1, 1, 1, 3'b101, 32'h100, 32'h8000_F0A5, 0, 4, 32'h0000_F0A5, 1);
    add("lw",   1, 1, 1, 3'b010, 32'h100, 32'h8000_F0A5, 0, 5, 32'h8000_F0A5, 1);
    add("lh_mis", 1, 1, 1, 3'b001, 32'h103, 32'h8000_F0A5, 0, 6, 32'hFFFF_8000, 1);
    add("lb_b3", 1, 1, 1, 3'b000, 32'h103, 32'h8000_F0A5, 0, 7, 32'hFFFF_FF80, 1);
    add("lwu32", 1, 1, 1, 3'b110, 32'h102, 32'h8000_F0A5, 0, 8, 32'h8000_F0A5, 1);
    add("f3_111", 1, 1, 1, 3'b111, 32'h101, 32'h8000_F0A5, 0, 9, 32'h8000_F0A5, 1);
    add("pc4",  1, 1, 2, 3'b000, 32'h999, 32'h1, 32'h44, 10, 32'h44, 1);
    add("src11", 1, 1, 3, 3'b000, 32'h1234, 32'h1, 32'h44, 11, 32'h1234, 1);
    add("x0",   1, 1, 0, 3'b000, 32'h77, 0, 0, 0, 32'h77, 0);
    add("rd5",  1, 1, 0, 3'b000, 32'h78, 0, 0, 5, 32'h78, 1);
    add("inval", 0, 1, 0, 3'b000, 32'h79, 0, 0, 5, 32'h79, 0);
    add("nowe", 1, 0, 0, 3'b000, 32'h7A, 0, 0, 5, 32'h7A, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].s, vecs[i].f,
            vecs[i].a, vecs[i].r, vecs[i].p, vecs[i].rd);
      tick();
      chk({vecs[i].name, "_res"}, 64'(ResultW), 64'(vecs[i].e_res));
      chk({vecs[i].name, "_we"}, 64'(RegWriteW_wb), 64'(vecs[i].e_we));
      chk({vecs[i].name, "_rd"}, 64'(RdW_wb), 64'(vecs[i].rd));
      chk({vecs[i].name, "_vld"}, 64'(ValidW), 64'(vecs[i].v));
    end

    // Stall holds rd=7 while inputs change.
    drive(1, 1, 0, 0, 32'hAA, 0, 0, 5'd7);
    tick();
    for (int i = 0; i < 3; i++) begin
      StallW = 1;
      drive(1, 1, 2'd2, 3'd1, $urandom, $urandom, $urandom, 5'(i + 12));
      tick();
      chk("stall_rd", 64'(RdW_wb), 7);
      chk("stall_res", 64'(ResultW), 64'hAA);
      chk("stall_we", 64'(RegWriteW_wb), 1);
    end
    FlushW = 1;
    tick();
    chk("flush_vld", 64'(ValidW), 0);
    chk("flush_we", 64'(RegWriteW_wb), 0);
    chk("flush_res", 64'(ResultW), 0);
    StallW = 0; FlushW = 0;

    // Reset while stalled, then normal capture.
    drive(1, 1, 0, 0, 32'h66, 0, 0, 5'd9);
    tick();
    StallW = 1; rst = 0;
    tick();
    chk("rst_stall_vld", 64'(ValidW), 0);
    chk("rst_stall_rd", 64'(RdW_wb), 0);
    rst = 1; StallW = 0;
    drive(1, 1, 0, 0, 32'h77, 0, 0, 5'd12);
    tick();
    chk("rst_rel_rd", 64'(RdW_wb), 12);
    chk("rst_rel_res", 64'(ResultW), 64'h77);

`ifdef WB_RETIRE_CNT_EN
    rst = 0;
    tick();
    rst = 1;
    begin
      logic sv[10];
      logic ss[10];
      sv = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
      ss = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 10; i++) begin
        StallW = ss[i];
        drive(sv[i], 1, 0, 0, 32'(i), 0, 0, 5'd1);
        tick();
      end
    end
    chk("retire5", 64'(RetireCount), 5);
    StallW = 0;
    rst = 0;
    tick();
    rst = 1;
    drive(1, 1, 0, 0, 32'h1, 0, 0, 5'd1);
    for (int i = 0; i < 16; i++) tick();
    chk("retire15", 64'(RetireCount), 15);
    tick();
    chk("retire_wrap", 64'(RetireCount), 0);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom % 40) != 0;
      StallW = ($urandom % 5) == 0;
      FlushW = ($urandom % 8) == 0;
      drive(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, 5'($urandom));
      tick();
      chk("rnd_vld", 64'(ValidW), 64'(m_valid));
      chk("rnd_we", 64'(RegWriteW_wb), 64'(m_rw && m_valid && m_rd != 0));
      chk("rnd_rd", 64'(RdW_wb), 64'(m_rd));
      chk("rnd_res", 64'(ResultW), 64'(ref_result()));
`ifdef WB_RETIRE_CNT_EN
      chk("rnd_cnt", 64'(RetireCount), 64'(m_cnt));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
